seven_seg_scanner: RTL and testbench

Parametrised time-multiplexed driver for a bank of common-anode 7-segment digits. Latches a packed BCD/hex value, commits it at frame boundaries to avoid tearing, and scans one digit at a time with per-digit decimal-point, blanking and leading-zero suppression. It sits between the player's status/timer logic and the board's segment and anode pins, replacing per-digit static decoders.

---
 rtl/seven_seg_scanner.sv | 172 +++++++++++++++++
 tb/tb_seven_seg_scanner.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed driver for a bank of common-anode
// 7-segment digits. A packed nibble value is captured into a shadow copy on
// 'load' and committed to the display registers only when the scan wraps
// back to digit 0, so a frame never shows a mix of old and new digits.
// Optional feature macro: SEVEN_SEG_HEX_EN (hex glyphs for codes 10-15).
module seven_seg_scanner #(
    parameter int NUM_DIGITS = 6,
    parameter int SCAN_DIV   = 50000,
    parameter int BLANK_CYC  = 500
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic                    load,
    input  logic                    lz_suppress,
    input  logic                    hex_mode,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic [7:0]              leds,
    output logic                    frame_tick
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);

    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic                    slot_end;
    logic                    frame_wrap;

    logic [4*NUM_DIGITS-1:0] shadow_value;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic [NUM_DIGITS-1:0]   shadow_blank;
    logic                    pending;

    logic [4*NUM_DIGITS-1:0] disp_value;
    logic [NUM_DIGITS-1:0]   disp_dp;
    logic [NUM_DIGITS-1:0]   disp_blank;

    logic [3:0]              cur_code;
    logic                    cur_dp;
    logic                    cur_blank;
    logic                    cur_lead_zero;
    logic                    zero_run;
    logic [7:0]              glyph;
    logic [NUM_DIGITS-1:0]   next_sel;
    logic [7:0]              next_leds;

    assign slot_end   = (cnt == CNT_LAST);
    assign frame_wrap = slot_end && (idx == IDX_LAST);

    // Prescaler and digit index: one slot of SCAN_DIV cycles per digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Shadow capture on load; the display copy is only refreshed at the frame
    // wrap, and a load landing on that same cycle re-arms pending for the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_value <= '0;
            shadow_dp    <= '0;
            shadow_blank <= '0;
            pending      <= 1'b0;
            disp_value   <= '0;
            disp_dp      <= '0;
            disp_blank   <= '0;
        end else begin
            if (frame_wrap && pending) begin
                disp_value <= shadow_value;
                disp_dp    <= shadow_dp;
                disp_blank <= shadow_blank;
                pending    <= 1'b0;
            end
            if (load) begin
                shadow_value <= value;
                shadow_dp    <= dp_mask;
                shadow_blank <= blank_mask;
                pending      <= 1'b1;
            end
        end
    end

    // Select the current digit's fields and whether it sits in the leading-zero run.
    always_comb begin
        cur_code      = 4'h0;
        cur_dp        = 1'b0;
        cur_blank     = 1'b0;
        cur_lead_zero = 1'b0;
        zero_run      = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run = zero_run && (disp_value[4*k +: 4] == 4'h0);
            if (idx == IDX_W'(k)) begin
                cur_code      = disp_value[4*k +: 4];
                cur_dp        = disp_dp[k];
                cur_blank     = disp_blank[k];
                cur_lead_zero = zero_run && (k != 0);
            end
        end
    end

    // Glyph lookup, active low with the DP bit left off.
    always_comb begin
        glyph = 8'hBF;
        case (cur_code)
            4'd0: glyph = 8'hC0;
            4'd1: glyph = 8'hF9;
            4'd2: glyph = 8'hA4;
            4'd3: glyph = 8'hB0;
            4'd4: glyph = 8'h99;
            4'd5: glyph = 8'h92;
            4'd6: glyph = 8'h82;
            4'd7: glyph = 8'hF8;
            4'd8: glyph = 8'h80;
            4'd9: glyph = 8'h90;
`ifdef SEVEN_SEG_HEX_EN
            4'd10: glyph = hex_mode ? 8'h88 : 8'hBF;
            4'd11: glyph = hex_mode ? 8'h83 : 8'hBF;
            4'd12: glyph = hex_mode ? 8'hC6 : 8'hBF;
            4'd13: glyph = hex_mode ? 8'hA1 : 8'hBF;
            4'd14: glyph = hex_mode ? 8'h86 : 8'hBF;
            4'd15: glyph = hex_mode ? 8'h8E : 8'hBF;
`endif
            default: glyph = 8'hBF;
        endcase
    end

`ifndef SEVEN_SEG_HEX_EN
    logic unused_hex_mode;
    assign unused_hex_mode = hex_mode;
`endif

    // Next anode/segment pattern: dark during the anti-ghosting window or for a
    // blanked digit, otherwise the glyph (or dark for a suppressed zero) plus DP.
    always_comb begin
        next_sel  = '1;
        next_leds = 8'hFF;
        if (!(cnt < BLANK_END) && !cur_blank) begin
            next_sel  = ~(NUM_DIGITS'(1) << idx);
            next_leds = (lz_suppress && cur_lead_zero) ? 8'hFF : glyph;
            if (cur_dp) begin
                next_leds[7] = 1'b0;
            end
        end
    end

    // Registered outputs; the tick marks the first output cycle of digit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_sel  <= '1;
            leds       <= 8'hFF;
            frame_tick <= 1'b0;
        end else begin
            digit_sel  <= next_sel;
            leds       <= next_leds;
            frame_tick <= (cnt == '0) && (idx == '0);
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: directed bench for seven_seg_scanner with a 4-digit
// bank, 4-cycle slots and a 1-cycle blanking window.
module tb_seven_seg_scanner;

    localparam int ND = 4;

    logic          clk;
    logic          rst_n;
    logic [15:0]   value;
    logic [3:0]    dp_mask;
    logic [3:0]    blank_mask;
    logic          load;
    logic          lz_suppress;
    logic          hex_mode;
    logic [3:0]    digit_sel;
    logic [7:0]    leds;
    logic          frame_tick;

    int checks;
    int errors;

    typedef struct {
        logic [15:0] value;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic        lz;
        logic        hex;
        logic [31:0] exp_leds;
    } vec_t;

    vec_t vecs [9];

    seven_seg_scanner #(
        .NUM_DIGITS(4),
        .SCAN_DIV  (4),
        .BLANK_CYC (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value      (value),
        .dp_mask    (dp_mask),
        .blank_mask (blank_mask),
        .load       (load),
        .lz_suppress(lz_suppress),
        .hex_mode   (hex_mode),
        .digit_sel  (digit_sel),
        .leds       (leds),
        .frame_tick (frame_tick)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare all three outputs against the expected pattern.
    task automatic check_output(input string name, input logic [3:0] exp_sel,
                                input logic [7:0] exp_leds, input logic exp_tick);
        checks++;
        if (digit_sel !== exp_sel || leds !== exp_leds || frame_tick !== exp_tick) begin
            errors++;
            $display("[TB] FAIL %s: got sel=%h leds=%h tick=%b, expected sel=%h leds=%h tick=%b",
                     name, digit_sel, leds, frame_tick, exp_sel, exp_leds, exp_tick);
        end
    endtask

    // Advance to the next sample with frame_tick high, bounded to 40 cycles.
    task automatic wait_tick(input string name);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: frame_tick never seen within 40 cycles", name);
        end
    endtask

    // Check a whole frame starting at its tick sample.
    task automatic check_frame(input string name, input logic [31:0] exp_leds,
                               input logic [3:0] blank);
        logic [3:0] es;
        logic [7:0] el;
        wait_tick(name);
        for (int d = 0; d < ND; d++) begin
            for (int p = 0; p < 4; p++) begin
                if (!(d == 0 && p == 0)) @(negedge clk);
                if (p == 0 || blank[d]) begin
                    es = 4'hF;
                    el = 8'hFF;
                end else begin
                    es = ~(4'b0001 << d);
                    el = exp_leds[8*d +: 8];
                end
                check_output($sformatf("%s d%0d p%0d", name, d, p), es, el, (d == 0 && p == 0));
            end
        end
    endtask

    // Drive levels and pulse load for one cycle.
    task automatic apply_stimulus(input vec_t v);
        @(negedge clk);
        value       = v.value;
        dp_mask     = v.dp;
        blank_mask  = v.blank;
        lz_suppress = v.lz;
        hex_mode    = v.hex;
        load        = 1'b1;
        @(negedge clk);
        load        = 1'b0;
    endtask

    initial begin
        logic [31:0] hex_exp;
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        value       = '0;
        dp_mask     = '0;
        blank_mask  = '0;
        load        = 1'b0;
        lz_suppress = 1'b0;
        hex_mode    = 1'b0;

`ifdef SEVEN_SEG_HEX_EN
        hex_exp = 32'h8883C6A1;
`else
        hex_exp = 32'hBFBFBFBF;
`endif
        vecs[0] = '{16'h1234, 4'b0010, 4'b0000, 1'b0, 1'b0, 32'hF9A43099};
        vecs[1] = '{16'h0050, 4'b0000, 4'b0000, 1'b1, 1'b0, 32'hFFFF92C0};
        vecs[2] = '{16'h0050, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'hC0C092C0};
        vecs[3] = '{16'hABCD, 4'b0000, 4'b0000, 1'b0, 1'b1, hex_exp};
        vecs[4] = '{16'hABCD, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'hBFBFBFBF};
        vecs[5] = '{16'h5678, 4'b0000, 4'b0100, 1'b0, 1'b0, 32'h92FFF880};
        vecs[6] = '{16'h0000, 4'b0100, 4'b0000, 1'b1, 1'b0, 32'hFF7FFFC0};
        vecs[7] = '{16'h9000, 4'b0000, 4'b0000, 1'b1, 1'b0, 32'h90C0C0C0};
        vecs[8] = '{16'h00E0, 4'b0000, 4'b0000, 1'b1, 1'b0, 32'hFFFFBFC0};

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        check_output("reset", 4'hF, 8'hFF, 1'b0);
        rst_n = 1'b1;

        // Scan from reset with an all-zero display.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check_output($sformatf("scan %0d", i),
                         (i % 4 == 0) ? 4'hF : ~(4'b0001 << (i / 4)),
                         (i % 4 == 0) ? 8'hFF : 8'hC0, (i == 0));
        end

        // Mid-frame load must not disturb the frame in progress.
        for (int s = 0; s < 16; s++) begin
            @(negedge clk);
            check_output($sformatf("midload %0d", s),
                         (s % 4 == 0) ? 4'hF : ~(4'b0001 << (s / 4)),
                         (s % 4 == 0) ? 8'hFF : 8'hC0, (s == 0));
            if (s == 5) begin
                value   = 16'h1234;
                dp_mask = 4'b0010;
                load    = 1'b1;
            end
            if (s == 6) load = 1'b0;
        end
        check_frame("after midload", 32'hF9A43099, 4'b0000);

        // Table of loaded patterns.
        for (int i = 0; i < 9; i++) begin
            apply_stimulus(vecs[i]);
            check_frame($sformatf("vec %0d", i), vecs[i].exp_leds, vecs[i].blank);
        end

        // Reset during digit 2's active window with a load still pending.
        @(negedge clk);
        value   = 16'h8888;
        dp_mask = 4'b0000;
        load    = 1'b1;
        @(negedge clk);
        load    = 1'b0;
        for (int n = 2; n <= 10; n++) @(negedge clk);
        check_output("pre-reset d2", 4'b1011, 8'hFF, 1'b0);
        #1 rst_n = 1'b0;
        #1 check_output("async reset", 4'hF, 8'hFF, 1'b0);
        @(negedge clk);
        check_output("held reset", 4'hF, 8'hFF, 1'b0);
        lz_suppress = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_output($sformatf("restart %0d", i),
                         (i % 4 == 0) ? 4'hF : ~(4'b0001 << (i / 4)),
                         (i % 4 == 0) ? 8'hFF : 8'hC0, (i == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
